// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared constants and types for the writeback arbiter slice.
//   WORD_WIDTH, REGFILE_BITS, REGFILE_SIZE : register-file geometry
//   WB_FIFO_DEPTH    : default vector-result buffer depth
//   WB_STARVE_LIMIT  : default starvation-guard threshold
//   wb_src_e         : which source drives the register-file write port
package wb_arbiter_pkg;

  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned REGFILE_BITS    = 5;
  localparam int unsigned REGFILE_SIZE    = 2 ** REGFILE_BITS;
  localparam int unsigned WB_FIFO_DEPTH   = 4;
  localparam int unsigned WB_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    WB_SRC_NONE   = 2'd0,
    WB_SRC_SCALAR = 2'd1,
    WB_SRC_VECTOR = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous in-order FIFO for vector-coprocessor scalar results.
// Ports:
//   clk, nrst              : clock, synchronous active-low reset
//   push, push_dest/data   : enqueue request (caller guarantees !full)
//   pop                    : dequeue request (caller guarantees !empty)
//   head_dest, head_data   : entry at the read pointer
//   full, empty            : occupancy flags from the registered count
//   ent_valid, ent_dest    : per-entry valid bit and destination register
module wb_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             push,
  input  logic [ADDR_BITS-1:0]             push_dest,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [ADDR_BITS-1:0]             head_dest,
  output logic [WIDTH-1:0]                 head_data,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][ADDR_BITS-1:0]  ent_dest
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_dest = ent_dest[rd_ptr];
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]       <= push_data;
        ent_dest[wr_ptr]  <= push_dest;
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter in front of the integer register-file write port.
// Scalar writeback has priority and is registered with one-cycle latency;
// vector-coprocessor results are queued and drained when the scalar path idles.
// Optional macro WB_ARB_STARVE_GUARD_EN enables the starvation guard (sc_stall).
// Ports:
//   clk, nrst                              : clock, synchronous active-low reset
//   sc_wr_en, sc_dest_addr, sc_wr_data     : scalar writeback
//   vc_valid, vc_ready, vc_dest_addr, vc_data : vector-result handshake
//   rf_wr_en, rf_dest_addr, rf_wr_data     : register-file write port
//   pend_mask                              : registers targeted by queued vector results
//   fifo_full                              : vector buffer full
//   sc_stall                               : request to freeze scalar writeback
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = wb_arbiter_pkg::WORD_WIDTH,
  parameter int unsigned REGFILE_BITS = wb_arbiter_pkg::REGFILE_BITS,
  parameter int unsigned FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         sc_wr_en,
  input  logic [REGFILE_BITS-1:0]      sc_dest_addr,
  input  logic [WORD_WIDTH-1:0]        sc_wr_data,
  input  logic                         vc_valid,
  output logic                         vc_ready,
  input  logic [REGFILE_BITS-1:0]      vc_dest_addr,
  input  logic [WORD_WIDTH-1:0]        vc_data,
  output logic                         rf_wr_en,
  output logic [REGFILE_BITS-1:0]      rf_dest_addr,
  output logic [WORD_WIDTH-1:0]        rf_wr_data,
  output logic [2**REGFILE_BITS-1:0]   pend_mask,
  output logic                         fifo_full,
  output logic                         sc_stall
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1)
  begin : g_param_check
    $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic                                        sc_wins;
  logic                                        push;
  logic                                        pop;
  logic                                        fifo_empty;
  logic [REGFILE_BITS-1:0]                     head_dest;
  logic [WORD_WIDTH-1:0]                       head_data;
  logic [FIFO_DEPTH-1:0]                       ent_valid;
  logic [FIFO_DEPTH-1:0][REGFILE_BITS-1:0]     ent_dest;
  wb_src_e                                     src;

  // Writes to x0 are architectural no-ops on both paths.
  assign sc_wins  = sc_wr_en && (sc_dest_addr != '0);
  assign vc_ready = !fifo_full;
  assign push     = vc_valid && vc_ready && (vc_dest_addr != '0);
  assign pop      = (src == WB_SRC_VECTOR);

  always_comb begin
    src = WB_SRC_NONE;
    if (sc_wins)          src = WB_SRC_SCALAR;
    else if (!fifo_empty) src = WB_SRC_VECTOR;
  end

  wb_fifo #(
    .WIDTH     (WORD_WIDTH),
    .ADDR_BITS (REGFILE_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push),
    .push_dest (vc_dest_addr),
    .push_data (vc_data),
    .pop       (pop),
    .head_dest (head_dest),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_dest  (ent_dest)
  );

  // An entry leaves the FIFO at the edge it is registered onto rf_*, so the
  // valid bits alone already exclude the write currently on the port.
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pend_mask[ent_dest[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rf_wr_en     <= 1'b0;
      rf_dest_addr <= '0;
      rf_wr_data   <= '0;
    end else begin
      case (src)
        WB_SRC_SCALAR: begin
          rf_wr_en     <= 1'b1;
          rf_dest_addr <= sc_dest_addr;
          rf_wr_data   <= sc_wr_data;
        end
        WB_SRC_VECTOR: begin
          rf_wr_en     <= 1'b1;
          rf_dest_addr <= head_dest;
          rf_wr_data   <= head_data;
        end
        default: rf_wr_en <= 1'b0;
      endcase
    end
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          stall_q;

  // Counter saturates at STARVE_LIMIT; stall asserts on the edge that brings
  // the count to the limit and drops on the first drain.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (pop) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (sc_wins && !fifo_empty) begin
      if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
      if (starve_cnt == SW'(STARVE_LIMIT - 1)) stall_q <= 1'b1;
    end
  end

  assign sc_stall = stall_q;
`else
  assign sc_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk;
  logic        nrst;
  logic        sc_wr_en;
  logic [4:0]  sc_dest_addr;
  logic [31:0] sc_wr_data;
  logic        vc_valid;
  logic        vc_ready;
  logic [4:0]  vc_dest_addr;
  logic [31:0] vc_data;
  logic        rf_wr_en;
  logic [4:0]  rf_dest_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] pend_mask;
  logic        fifo_full;
  logic        sc_stall;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  wb_arbiter #(
    .WORD_WIDTH   (32),
    .REGFILE_BITS (5),
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .sc_wr_en     (sc_wr_en),
    .sc_dest_addr (sc_dest_addr),
    .sc_wr_data   (sc_wr_data),
    .vc_valid     (vc_valid),
    .vc_ready     (vc_ready),
    .vc_dest_addr (vc_dest_addr),
    .vc_data      (vc_data),
    .rf_wr_en     (rf_wr_en),
    .rf_dest_addr (rf_dest_addr),
    .rf_wr_data   (rf_wr_data),
    .pend_mask    (pend_mask),
    .fifo_full    (fifo_full),
    .sc_stall     (sc_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input logic [4:0] r);
    logic [31:0] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

`ifdef WB_ARB_STARVE_GUARD_EN
  always @(posedge clk) begin
    if (nrst && sc_stall && sc_wr_en) begin
      miscompares++;
      $error("FAIL sc_protocol: scalar write 0x%0h presented while stalled, expected none", sc_dest_addr);
    end
  end
`endif

  logic [4:0]  q_dest[$];
  logic [31:0] q_data[$];
  logic [31:0] exp_mask;
  logic        exp_stall;

  initial begin
    nrst = 1'b0; sc_wr_en = 1'b0; sc_dest_addr = '0; sc_wr_data = '0;
    vc_valid = 1'b0; vc_dest_addr = '0; vc_data = '0;
    step();
    step();
    check("rst_rf_wr_en", rf_wr_en, 0);
    check("rst_rf_dest", rf_dest_addr, 0);
    check("rst_rf_data", rf_wr_data, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ready", vc_ready, 1);
    check("rst_stall", sc_stall, 0);
    nrst = 1'b1;

    // Scalar only
    sc_wr_en = 1'b1; sc_dest_addr = 5'd5; sc_wr_data = 32'hDEADBEEF;
    step();
    check("sc_wr_en", rf_wr_en, 1);
    check("sc_dest", rf_dest_addr, 5);
    check("sc_data", rf_wr_data, 32'hDEADBEEF);
    sc_dest_addr = 5'd0; sc_wr_data = 32'h11111111;
    step();
    check("sc_x0_wr_en", rf_wr_en, 0);
    check("sc_x0_dest_hold", rf_dest_addr, 5);
    check("sc_x0_data_hold", rf_wr_data, 32'hDEADBEEF);
    sc_wr_en = 1'b0;

    // Vector only
    vc_valid = 1'b1; vc_dest_addr = 5'd7; vc_data = 32'h12345678;
    step();
    vc_valid = 1'b0;
    check("vc_pend7", pend_mask, 32'h80);
    check("vc_wr_en_early", rf_wr_en, 0);
    step();
    check("vc_wr_en", rf_wr_en, 1);
    check("vc_dest", rf_dest_addr, 7);
    check("vc_data", rf_wr_data, 32'h12345678);
    check("vc_pend_clear", pend_mask, 0);
    step();
    check("vc_idle", rf_wr_en, 0);

    // Priority: scalar busy while four vector results queue up
    sc_wr_en = 1'b1; sc_dest_addr = 5'd10; sc_wr_data = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      vc_valid = 1'b1; vc_dest_addr = 5'(i); vc_data = 32'h100 + 32'(i);
      step();
    end
    check("prio_full", fifo_full, 1);
    check("prio_ready", vc_ready, 0);
    check("prio_pend", pend_mask, 32'h1E);
    check("prio_sc_dest", rf_dest_addr, 10);
    vc_dest_addr = 5'd9; vc_data = 32'h999;
    step();
    vc_valid = 1'b0;
    check("prio_full_hold", fifo_full, 1);
    check("prio_no_push_full", pend_mask, 32'h1E);
    sc_wr_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("drain_wr_en", rf_wr_en, 1);
      check("drain_dest", rf_dest_addr, 64'(i));
      check("drain_data", rf_wr_data, 64'h100 + 64'(i));
      if (i == 1) check("drain_ready", vc_ready, 1);
    end
    step();
    check("drain_done", rf_wr_en, 0);
    check("drain_pend", pend_mask, 0);

    // x0 vector result: handshake completes but nothing is queued
    vc_valid = 1'b1; vc_dest_addr = 5'd0; vc_data = 32'hBAD;
    check("x0_ready", vc_ready, 1);
    step();
    vc_valid = 1'b0;
    check("x0_pend", pend_mask, 0);
    step();
    check("x0_no_write", rf_wr_en, 0);

    // Simultaneous push/pop at occupancy 2, across pointer wrap
    sc_wr_en = 1'b1; sc_dest_addr = 5'd10;
    vc_valid = 1'b1; vc_dest_addr = 5'd11; vc_data = 32'h200;
    step();
    q_dest.push_back(5'd11); q_data.push_back(32'h200);
    vc_dest_addr = 5'd12; vc_data = 32'h201;
    step();
    q_dest.push_back(5'd12); q_data.push_back(32'h201);
    sc_wr_en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      vc_valid = 1'b1; vc_dest_addr = 5'(13 + j); vc_data = 32'h300 + 32'(j);
      step();
      check("pp_wr_en", rf_wr_en, 1);
      check("pp_dest", rf_dest_addr, q_dest.pop_front());
      check("pp_data", rf_wr_data, q_data.pop_front());
      q_dest.push_back(5'(13 + j)); q_data.push_back(32'h300 + 32'(j));
      exp_mask = onehot(q_dest[0]) | onehot(q_dest[1]);
      check("pp_pend", pend_mask, exp_mask);
      check("pp_full", fifo_full, 0);
    end
    vc_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      step();
      check("pp_tail_dest", rf_dest_addr, q_dest.pop_front());
      check("pp_tail_data", rf_wr_data, q_data.pop_front());
    end
    step();
    check("pp_empty", pend_mask, 0);

    // Reset mid-drain with three entries still queued
    sc_wr_en = 1'b1; sc_dest_addr = 5'd10;
    for (int i = 0; i < 4; i++) begin
      vc_valid = 1'b1; vc_dest_addr = 5'(20 + i); vc_data = 32'h400 + 32'(i);
      step();
    end
    vc_valid = 1'b0; sc_wr_en = 1'b0;
    step();
    check("rm_first_drain", rf_dest_addr, 20);
    check("rm_pend3", pend_mask, 32'h00E0_0000);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    check("rm_wr_en", rf_wr_en, 0);
    check("rm_pend", pend_mask, 0);
    check("rm_ready", vc_ready, 1);
    check("rm_dest", rf_dest_addr, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rm_no_write", rf_wr_en, 0);
    end

    // Starvation: one queued entry blocked by continuous scalar writes
    sc_wr_en = 1'b1; sc_dest_addr = 5'd3; sc_wr_data = 32'h33;
    vc_valid = 1'b1; vc_dest_addr = 5'd25; vc_data = 32'h2525;
    step();
    vc_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
`ifdef WB_ARB_STARVE_GUARD_EN
      exp_stall = (i == 8);
`else
      exp_stall = 1'b0;
`endif
      check("starve_stall", sc_stall, exp_stall);
    end
    sc_wr_en = 1'b0;
    step();
    check("starve_drain_dest", rf_dest_addr, 25);
    check("starve_drain_data", rf_wr_data, 32'h2525);
    check("starve_release", sc_stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
